// File: rtl/jtag_dmi_pkg.sv
// Shared constants for the JTAG debug transport: DMI op/resp codes,
// TAP instruction codes and the DTMCS field layout.
package jtag_dmi_pkg;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_RESP_SUCCESS = 2'd0,
    DMI_RESP_RSVD    = 2'd1,
    DMI_RESP_FAILED  = 2'd2,
    DMI_RESP_BUSY    = 2'd3
  } dmi_resp_e;

  // Instruction codes; anything not listed falls through to BYPASS.
  localparam int IR_IDCODE = 'h01;
  localparam int IR_DTMCS  = 'h10;
  localparam int IR_DMI    = 'h11;
  localparam int IR_BYPASS = 'h1f;

  // DTMCS field offsets.
  localparam int DTMCS_VERSION_LSB   = 0;
  localparam int DTMCS_ABITS_LSB     = 4;
  localparam int DTMCS_DMISTAT_LSB   = 10;
  localparam int DTMCS_IDLE_LSB      = 12;
  localparam int DTMCS_DMIRESET_BIT  = 16;
  localparam int DTMCS_HARDRESET_BIT = 17;
  localparam logic [3:0] DTMCS_VERSION = 4'd1;

  // Assemble the read-only DTMCS capture word.
  function automatic logic [31:0] dtmcs_word(input logic [5:0] abits,
                                             input logic [1:0] stat,
                                             input logic [2:0] idle);
    logic [31:0] w;
    w = '0;
    w[DTMCS_VERSION_LSB +: 4] = DTMCS_VERSION;
    w[DTMCS_ABITS_LSB +: 6]   = abits;
    w[DTMCS_DMISTAT_LSB +: 2] = stat;
    w[DTMCS_IDLE_LSB +: 3]    = idle;
    return w;
  endfunction

endpackage

// File: rtl/jtag_dmi_req_ctrl.sv
// DMI request/response tracking: outstanding flag, sticky status, response
// data, request handshake register and the hard-reset response discard.
module jtag_dmi_req_ctrl
  import jtag_dmi_pkg::*;
#(
  parameter int unsigned ABITS = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture_dmi,
  input  logic             update_dmi,
  input  logic             update_dtmcs,
  input  logic [ABITS-1:0] upd_addr,
  input  logic [31:0]      upd_data,
  input  logic [1:0]       upd_op,
  input  logic             dmireset,
  input  logic             hardreset,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_rsp_valid,
  input  logic [31:0]      dmi_rsp_data,
  input  logic [1:0]       dmi_rsp_resp,
  output logic             dtm_hardreset,
  output logic [ABITS-1:0] last_addr,
  output logic [31:0]      cap_data,
  output logic [1:0]       cap_stat,
  output logic [1:0]       dmistat_fwd
);

  logic        busy_q;
  logic        discard_q;
  logic [1:0]  dmistat_q;
  logic [31:0] rsp_data_q;
  logic [1:0]  dmistat_next;
  logic        rsp_accept;
  logic        rsp_take;
  logic        busy_fwd;
  logic        op_is_rw;
  logic        issue;

  // A response only counts while an op is outstanding; a discarded one
  // still retires the op but leaves data and status alone.
  assign rsp_accept = dmi_rsp_valid & busy_q;
  assign rsp_take   = rsp_accept & ~discard_q;
  // Busy as seen by a same-cycle scan event, after forwarding the response.
  assign busy_fwd   = busy_q & ~dmi_rsp_valid;
  assign op_is_rw   = (upd_op == DMI_OP_READ) || (upd_op == DMI_OP_WRITE);
  assign issue      = update_dmi & ~busy_fwd & op_is_rw &
                      (dmistat_fwd == DMI_RESP_SUCCESS);

  assign cap_data = rsp_take ? dmi_rsp_data : rsp_data_q;
  assign cap_stat = busy_fwd ? DMI_RESP_BUSY : dmistat_fwd;

  // Forwarded status and next sticky status; a reset write wins over all.
  always_comb begin
    dmistat_fwd = dmistat_q;
    if (rsp_take && dmi_rsp_resp == DMI_RESP_FAILED && dmistat_q != DMI_RESP_BUSY)
      dmistat_fwd = DMI_RESP_FAILED;
    dmistat_next = dmistat_fwd;
    if ((capture_dmi || update_dmi) && busy_fwd)
      dmistat_next = DMI_RESP_BUSY;
    if (update_dtmcs && (dmireset || hardreset))
      dmistat_next = DMI_RESP_SUCCESS;
  end

  // Request, outstanding-op and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= 1'b0;
      discard_q     <= 1'b0;
      dmistat_q     <= DMI_RESP_SUCCESS;
      rsp_data_q    <= '0;
      last_addr     <= '0;
      dmi_req_valid <= 1'b0;
      dmi_req_addr  <= '0;
      dmi_req_data  <= '0;
      dmi_req_op    <= DMI_OP_NOP;
      dtm_hardreset <= 1'b0;
    end else begin
      dmistat_q     <= dmistat_next;
      rsp_data_q    <= cap_data;
      dtm_hardreset <= update_dtmcs & hardreset;
      if (issue)
        busy_q <= 1'b1;
      else if (dmi_rsp_valid)
        busy_q <= 1'b0;
      if (update_dtmcs && hardreset && busy_fwd)
        discard_q <= 1'b1;
      else if (rsp_accept)
        discard_q <= 1'b0;
      if (update_dmi)
        last_addr <= upd_addr;
      if (issue) begin
        dmi_req_valid <= 1'b1;
        dmi_req_addr  <= upd_addr;
        dmi_req_data  <= upd_data;
        dmi_req_op    <= upd_op;
      end else if (dmi_req_ready) begin
        dmi_req_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jtag_dtm_v2.sv
// RISC-V debug transport: TAP data registers, TDO mux and the DMI
// request controller.
module jtag_dtm_v2
  import jtag_dmi_pkg::*;
#(
  parameter int unsigned ABITS        = 7,
  parameter int unsigned IR_WIDTH     = 5,
  parameter logic [31:0] IDCODE_VALUE = 32'h1DEAD3FF,
  parameter int unsigned IDLE_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tdi,
  output logic                tdo,
  input  logic                capture_dr,
  input  logic                shift_dr,
  input  logic                update_dr,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                dmi_req_valid,
  input  logic                dmi_req_ready,
  output logic [ABITS-1:0]    dmi_req_addr,
  output logic [31:0]         dmi_req_data,
  output logic [1:0]          dmi_req_op,
  input  logic                dmi_rsp_valid,
  input  logic [31:0]         dmi_rsp_data,
  input  logic [1:0]          dmi_rsp_resp,
  output logic                dtm_hardreset,
  output logic [31:0]         idcode
);

  localparam int DMI_W = ABITS + 34;

  logic             sel_idcode, sel_dtmcs, sel_dmi;
  logic [31:0]      idcode_sr;
  logic [31:0]      dtmcs_sr;
  logic [DMI_W-1:0] dmi_sr;
  logic             bypass_sr;
  logic [ABITS-1:0] last_addr;
  logic [31:0]      cap_data;
  logic [1:0]       cap_stat;
  logic [1:0]       dmistat_fwd;

  assign idcode     = IDCODE_VALUE;
  assign sel_idcode = (ir_out == IR_WIDTH'(IR_IDCODE));
  assign sel_dtmcs  = (ir_out == IR_WIDTH'(IR_DTMCS));
  assign sel_dmi    = (ir_out == IR_WIDTH'(IR_DMI));

  // TAP data registers: capture parallel value, then shift right from tdi.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idcode_sr <= IDCODE_VALUE;
      dtmcs_sr  <= '0;
      dmi_sr    <= '0;
      bypass_sr <= 1'b0;
    end else if (capture_dr) begin
      if (sel_idcode)
        idcode_sr <= IDCODE_VALUE;
      else if (sel_dtmcs)
        dtmcs_sr <= dtmcs_word(6'(ABITS), dmistat_fwd, 3'(IDLE_CYCLES));
      else if (sel_dmi)
        dmi_sr <= {last_addr, cap_data, cap_stat};
      else
        bypass_sr <= 1'b0;
    end else if (shift_dr) begin
      if (sel_idcode)
        idcode_sr <= {tdi, idcode_sr[31:1]};
      else if (sel_dtmcs)
        dtmcs_sr <= {tdi, dtmcs_sr[31:1]};
      else if (sel_dmi)
        dmi_sr <= {tdi, dmi_sr[DMI_W-1:1]};
      else
        bypass_sr <= tdi;
    end
  end

  // TDO is the LSB of whichever register the instruction selects.
  always_comb begin
    tdo = bypass_sr;
    if (sel_idcode)
      tdo = idcode_sr[0];
    else if (sel_dtmcs)
      tdo = dtmcs_sr[0];
    else if (sel_dmi)
      tdo = dmi_sr[0];
  end

  jtag_dmi_req_ctrl #(
    .ABITS(ABITS)
  ) u_req_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture_dmi  (capture_dr & sel_dmi),
    .update_dmi   (update_dr & sel_dmi),
    .update_dtmcs (update_dr & sel_dtmcs),
    .upd_addr     (dmi_sr[DMI_W-1:34]),
    .upd_data     (dmi_sr[33:2]),
    .upd_op       (dmi_sr[1:0]),
    .dmireset     (dtmcs_sr[DTMCS_DMIRESET_BIT]),
    .hardreset    (dtmcs_sr[DTMCS_HARDRESET_BIT]),
    .dmi_req_valid(dmi_req_valid),
    .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr (dmi_req_addr),
    .dmi_req_data (dmi_req_data),
    .dmi_req_op   (dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid),
    .dmi_rsp_data (dmi_rsp_data),
    .dmi_rsp_resp (dmi_rsp_resp),
    .dtm_hardreset(dtm_hardreset),
    .last_addr    (last_addr),
    .cap_data     (cap_data),
    .cap_stat     (cap_stat),
    .dmistat_fwd  (dmistat_fwd)
  );

endmodule
